pc_gen: RTL
===========

Name: pc_gen

Overview:
- Parametrised fetch-address generator; successor of the single-width PC register.
- Sits at the head of the IF stage and drives the instruction-memory address through a valid/ready handshake.
- Adds prioritised redirects (exception, exception return, branch, jump) and misaligned-target trapping.
- Adds a configurable post-reset boot delay and a debug halt/resume state.

Parameters:
- XLEN, 32, address width in bits
- RESET_VEC, 32'h0000_0000, first fetch address after reset
- TRAP_VEC, 32'h0000_0100, target on exception or misaligned redirect
- INSN_BYTES, 4, sequential increment; power of two, 2 or 4
- BOOT_DELAY, 1, cycles spent in BOOT after reset release; range 1..15

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; asynchronous, active-high
- stall  in  1  hazard stall (load-use etc.)
- br_taken  in  1  branch resolved taken
- br_target  in  XLEN  branch target
- jmp_valid  in  1  unconditional jump
- jmp_target  in  XLEN  jump target
- exc_valid  in  1  exception, redirect to TRAP_VEC
- eret_valid  in  1  exception return
- eret_target  in  XLEN  return address
- halt_req  in  1  debug halt request, level
- resume  in  1  debug resume, pulse
- pc  out  XLEN  fetch address
- pc_valid  out  1  fetch request valid
- pc_ready  in  1  imem accepts pc this cycle
- redirect  out  1  registered pulse: pc changed non-sequentially this cycle (IF flush)
- misalign  out  1  registered pulse: redirect target misaligned, trapped
- halted  out  1  in HALTED state

Behaviour:
- Reset (rst_n=1, async): state=BOOT, boot counter=0, pc=RESET_VEC; pc_valid, redirect, misalign, halted all 0.
- FSM BOOT: counter increments each clk; at count BOOT_DELAY-1 go to RUN. pc_valid=0. All redirects ignored.
- FSM RUN: pc_valid = !stall.
  - halt_req=1 and no handshake pending (pc_valid&&!pc_ready false) -> HALTED next cycle.
  - While halt_req=1 and a handshake is pending, the halt waits until that handshake completes.
- FSM HALTED: pc_valid=0, halted=1.
  - resume -> RUN.
  - Redirects still update pc but state stays HALTED.
- Next-pc priority per cycle (RUN or HALTED): exc_valid > eret_valid > br_taken > jmp_valid > stall hold > sequential.
- Redirect sources (exc/eret/br/jmp): pc <= target next cycle; redirect=1 next cycle.
  - Redirects override stall and any pending handshake; a pending request is abandoned.
- Misalignment: a non-exception target with target[log2(INSN_BYTES)-1:0] != 0 gives pc <= TRAP_VEC and misalign=1 next cycle, with redirect=1.
- Sequential advance: pc <= pc + INSN_BYTES only when pc_valid && pc_ready. Arithmetic is modulo 2^XLEN, so all-ones-aligned addresses wrap to 0.
- Handshake stability: while pc_valid && !pc_ready, pc is held stable unless a redirect occurs.
- stall=1 with no redirect: pc held, pc_valid=0.
- resume and halt_req asserted together in HALTED: resume wins for one cycle, then halt is re-taken on the next eligible cycle.
- Reset asserted mid-operation: immediate return to reset values regardless of state or pending handshake.

Decomposition:
- Shared package holds:
  - state enum (BOOT, RUN, HALTED)
  - redirect-source encoding (NONE, EXC, ERET, BR, JMP)
  - default RESET_VEC and TRAP_VEC constants, shared with the CSR block
- One sub-module, pc_redirect_mux: combinational priority select producing next target, source and misalign flag.
- FSM, boot counter and pc register stay in pc_gen.

Test Plan:
- Reset release, BOOT_DELAY=3, pc_ready=1 -> pc_valid=0 for exactly 3 cycles, then pc 0x0, 0x4, 0x8 on successive cycles.
- pc=0x10, pc_ready=0 for 2 cycles then 1 -> pc held at 0x10 with pc_valid=1, then pc=0x14.
- Same cycle exc_valid=1 and br_taken=1 with br_target=0x200, stall=1 -> pc=0x100, redirect=1, misalign=0.
- br_taken=1, br_target=0x202 (INSN_BYTES=4) -> pc=0x100, misalign=1, redirect=1.
- pc=0xFFFF_FFFC, accepted -> pc=0x0000_0000, no redirect pulse.
- halt_req=1 at pc=0x40 with pending handshake -> halted=1 only after the 0x40 accept; in HALTED, jmp_target=0x80 gives pc=0x80, halted stays 1; resume -> fetch resumes at 0x80.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// Shared types and reset/trap vector defaults for the fetch-address generator.
// The CSR block reads the vector constants from here as well.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALTED
  } state_t;

  typedef enum logic [2:0] {
    SRC_NONE,
    SRC_EXC,
    SRC_ERET,
    SRC_BR,
    SRC_JMP
  } redir_src_t;

  localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VEC  = 32'h0000_0100;

endpackage

// File: rtl/pc_gen_if.sv
// Instruction-memory fetch request channel: address plus valid/ready handshake.
interface pc_gen_if #(
  parameter int unsigned XLEN = 32
);
  logic [XLEN-1:0] pc;
  logic            pc_valid;
  logic            pc_ready;

  modport master (output pc, output pc_valid, input pc_ready);
  modport slave  (input pc, input pc_valid, output pc_ready);
endinterface

// File: rtl/pc_redirect_mux.sv
// Priority select among redirect sources; misaligned non-exception targets trap.
module pc_redirect_mux
  import pc_gen_pkg::*;
#(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] TRAP_VEC   = XLEN'(DEFAULT_TRAP_VEC),
  parameter int unsigned     INSN_BYTES = 4
) (
  input  logic            exc_valid,
  input  logic            eret_valid,
  input  logic [XLEN-1:0] eret_target,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            jmp_valid,
  input  logic [XLEN-1:0] jmp_target,
  output logic [XLEN-1:0] target,
  output redir_src_t      src,
  output logic            misalign
);

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSN_BYTES - 1);

  logic [XLEN-1:0] raw_target;

  always_comb begin
    src        = SRC_NONE;
    raw_target = TRAP_VEC;
    if (exc_valid) begin
      src = SRC_EXC;
    end else if (eret_valid) begin
      src        = SRC_ERET;
      raw_target = eret_target;
    end else if (br_taken) begin
      src        = SRC_BR;
      raw_target = br_target;
    end else if (jmp_valid) begin
      src        = SRC_JMP;
      raw_target = jmp_target;
    end
    // The exception vector is trusted aligned; only computed targets are checked.
    misalign = (src != SRC_NONE) && (src != SRC_EXC) && ((raw_target & ALIGN_MASK) != '0);
    target   = misalign ? TRAP_VEC : raw_target;
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch-address generator: boot delay, debug halt, prioritised redirects and
// sequential advance on accepted fetch requests.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_VEC  = XLEN'(DEFAULT_RESET_VEC),
  parameter logic [XLEN-1:0] TRAP_VEC   = XLEN'(DEFAULT_TRAP_VEC),
  parameter int unsigned     INSN_BYTES = 4,
  parameter int unsigned     BOOT_DELAY = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            jmp_valid,
  input  logic [XLEN-1:0] jmp_target,
  input  logic            exc_valid,
  input  logic            eret_valid,
  input  logic [XLEN-1:0] eret_target,
  input  logic            halt_req,
  input  logic            resume,
  pc_gen_if.master        fetch,
  output logic            redirect,
  output logic            misalign,
  output logic            halted
);

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_DELAY - 1);

  state_t          state_q, state_d;
  logic [3:0]      boot_cnt_q, boot_cnt_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            redirect_q, misalign_q;

  logic [XLEN-1:0] mux_target;
  redir_src_t      mux_src;
  logic            mux_misalign;
  logic            take_redirect;
  logic            pc_valid_int;
  logic            fire;
  logic            pending;

  pc_redirect_mux #(
    .XLEN       (XLEN),
    .TRAP_VEC   (TRAP_VEC),
    .INSN_BYTES (INSN_BYTES)
  ) u_mux (
    .exc_valid   (exc_valid),
    .eret_valid  (eret_valid),
    .eret_target (eret_target),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .jmp_valid   (jmp_valid),
    .jmp_target  (jmp_target),
    .target      (mux_target),
    .src         (mux_src),
    .misalign    (mux_misalign)
  );

  assign pc_valid_int  = (state_q == RUN) && !stall;
  assign fire          = pc_valid_int && fetch.pc_ready;
  assign pending       = pc_valid_int && !fetch.pc_ready;
  assign take_redirect = (state_q != BOOT) && (mux_src != SRC_NONE);

  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    unique case (state_q)
      BOOT: begin
        boot_cnt_d = boot_cnt_q + 4'd1;
        if (boot_cnt_q == BOOT_LAST) state_d = RUN;
      end
      RUN: begin
        if (halt_req && !pending) state_d = HALTED;
      end
      HALTED: begin
        if (resume) state_d = RUN;
      end
      default: state_d = BOOT;
    endcase
  end

  // Redirects win over both stall and an outstanding request, which is dropped.
  always_comb begin
    pc_d = pc_q;
    if (take_redirect) pc_d = mux_target;
    else if (fire)     pc_d = pc_q + XLEN'(INSN_BYTES);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q    <= BOOT;
      boot_cnt_q <= '0;
      pc_q       <= RESET_VEC;
      redirect_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      pc_q       <= pc_d;
      redirect_q <= take_redirect;
      misalign_q <= take_redirect && mux_misalign;
    end
  end

  assign fetch.pc       = pc_q;
  assign fetch.pc_valid = pc_valid_int;
  assign redirect       = redirect_q;
  assign misalign       = misalign_q;
  assign halted         = (state_q == HALTED);

endmodule
